// File: rtl/pipeline_ctrl_if.sv
// Hazard/memory control bundle between the pipeline datapath and pipeline_ctrl.
// The master side drives instruction and memory status; the slave side returns the controls.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_rs1;
    logic [4:0]       ID_rs2;
    logic [4:0]       EX_rd;
    logic             EX_MemRead;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ack;

    logic             Stall;
    logic             NoOp;
    logic             Flush;
    logic             cpu_stall_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] mem_stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output ID_rs1, ID_rs2, EX_rd, EX_MemRead, branch_taken, mem_req, mem_ack,
        input  Stall, NoOp, Flush, cpu_stall_o, err_o,
        input  stall_cnt_o, mem_stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  ID_rs1, ID_rs2, EX_rd, EX_MemRead, branch_taken, mem_req, mem_ack,
        output Stall, NoOp, Flush, cpu_stall_o, err_o,
        output stall_cnt_o, mem_stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-miss freeze
// with a timeout error state, and saturating performance counters.
module pipeline_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pipeline_ctrl_if.slave bus
);
    localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_mem_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_load_use;
    logic w_cpu_stall;
    logic w_stall;
    logic w_flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    // x0 is hardwired zero, so a load targeting it never creates a hazard.
    assign w_load_use = bus.EX_MemRead && (bus.EX_rd != 5'd0) &&
                        ((bus.EX_rd == bus.ID_rs1) || (bus.EX_rd == bus.ID_rs2));

    // A frozen pipeline holds everything, so hazard controls are masked; load-use beats flush.
    assign w_stall = w_load_use && !w_cpu_stall;
    assign w_flush = bus.branch_taken && !w_load_use && !w_cpu_stall;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_cpu_stall = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.mem_req && !bus.mem_ack) begin
                    w_state_nxt = MEM_WAIT;
                    w_wait_nxt  = '0;
                    w_cpu_stall = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ack) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cpu_stall = 1'b1;
                    w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
                    if (r_wait_cnt == WAIT_LAST)
                        w_state_nxt = ERR;
                end
            end
            ERR: begin
                w_cpu_stall = 1'b1;
            end
            default: begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt     <= '0;
            r_mem_stall_cnt <= '0;
            r_flush_cnt     <= '0;
        end else begin
            r_stall_cnt     <= sat_inc(r_stall_cnt, w_stall);
            r_mem_stall_cnt <= sat_inc(r_mem_stall_cnt, w_cpu_stall);
            r_flush_cnt     <= sat_inc(r_flush_cnt, w_flush);
        end
    end

    assign bus.Stall           = w_stall;
    assign bus.NoOp            = w_stall;
    assign bus.Flush           = w_flush;
    assign bus.cpu_stall_o     = w_cpu_stall;
    assign bus.err_o           = (r_state == ERR);
    assign bus.stall_cnt_o     = r_stall_cnt;
    assign bus.mem_stall_cnt_o = r_mem_stall_cnt;
    assign bus.flush_cnt_o     = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// against a behavioural model, on a default instance and a TIMEOUT=8/CNT_W=4 instance.
module tb_pipeline_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] t_rs1 = '0, t_rs2 = '0, t_rd = '0;
    logic       t_mr = 1'b0, t_br = 1'b0, t_req = 1'b0, t_ack = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(16)) ifa();
    pipeline_ctrl_if #(.CNT_W(4))  ifb();

    assign ifa.ID_rs1 = t_rs1;  assign ifb.ID_rs1 = t_rs1;
    assign ifa.ID_rs2 = t_rs2;  assign ifb.ID_rs2 = t_rs2;
    assign ifa.EX_rd  = t_rd;   assign ifb.EX_rd  = t_rd;
    assign ifa.EX_MemRead   = t_mr;  assign ifb.EX_MemRead   = t_mr;
    assign ifa.branch_taken = t_br;  assign ifb.branch_taken = t_br;
    assign ifa.mem_req      = t_req; assign ifb.mem_req      = t_req;
    assign ifa.mem_ack      = t_ack; assign ifb.mem_ack      = t_ack;

    pipeline_ctrl #(.TIMEOUT(255), .CNT_W(16)) dut_a (.clk_i(clk), .rst_i(rst_n), .bus(ifa));
    pipeline_ctrl #(.TIMEOUT(8),   .CNT_W(4))  dut_b (.clk_i(clk), .rst_i(rst_n), .bus(ifb));

    // Model: index 0 = default instance, 1 = small instance.
    bit m_miss[2];
    bit m_err[2];
    int m_wait[2];
    int m_sc[2], m_msc[2], m_fc[2];
    int tmo[2]  = '{255, 8};
    int cmax[2] = '{65535, 15};

    function automatic bit e_lu();
        return t_mr && (t_rd != 5'd0) && (t_rd == t_rs1 || t_rd == t_rs2);
    endfunction
    function automatic bit e_cpu(int k);
        return m_err[k] || (!t_ack && (m_miss[k] || t_req));
    endfunction
    function automatic bit e_stall(int k);
        return e_lu() && !e_cpu(k);
    endfunction
    function automatic bit e_flush(int k);
        return t_br && !e_lu() && !e_cpu(k);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_miss[k] = 0; m_err[k] = 0; m_wait[k] = 0;
            m_sc[k] = 0; m_msc[k] = 0; m_fc[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit st, fl, cs;
            st = e_stall(k); fl = e_flush(k); cs = e_cpu(k);
            if (st && m_sc[k]  < cmax[k]) m_sc[k]++;
            if (fl && m_fc[k]  < cmax[k]) m_fc[k]++;
            if (cs && m_msc[k] < cmax[k]) m_msc[k]++;
            if (!m_err[k]) begin
                if (m_miss[k]) begin
                    if (t_ack) m_miss[k] = 0;
                    else begin
                        m_wait[k]++;
                        if (m_wait[k] == tmo[k]) begin m_err[k] = 1; m_miss[k] = 0; end
                    end
                end else if (t_req && !t_ack) begin
                    m_miss[k] = 1; m_wait[k] = 0;
                end
            end
        end
    endtask

    task automatic advance();
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        t_rs1 = '0; t_rs2 = '0; t_rd = '0;
        t_mr = 0; t_br = 0; t_req = 0; t_ack = 0;
    endtask

    task automatic release_reset();
        idle_inputs();
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; #1;
        release_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle_inputs();
        repeat (2) @(posedge clk); #1;
        n_checks++; if (ifa.stall_cnt_o !== 16'd0 || ifa.mem_stall_cnt_o !== 16'd0 || ifa.flush_cnt_o !== 16'd0)
            $display("FAIL reset_cnt_a got %0d/%0d/%0d want 0/0/0", ifa.stall_cnt_o, ifa.mem_stall_cnt_o, ifa.flush_cnt_o);
        else n_pass++;
        n_checks++; if (ifa.err_o !== 1'b0 || ifb.err_o !== 1'b0 || ifa.cpu_stall_o !== 1'b0)
            $display("FAIL reset_err got err=%b/%b cpu=%b want 0/0/0", ifa.err_o, ifb.err_o, ifa.cpu_stall_o);
        else n_pass++;
        t_req = 1; #1;
        n_checks++; if (ifa.cpu_stall_o !== 1'b1)
            $display("FAIL reset_run_miss got %b want 1", ifa.cpu_stall_o);
        else n_pass++;
        t_req = 0; t_mr = 1; t_rd = 5'd7; t_rs1 = 5'd7; #1;
        n_checks++; if (ifa.Stall !== 1'b1 || ifb.NoOp !== 1'b1)
            $display("FAIL reset_load_use got %b/%b want 1/1", ifa.Stall, ifb.NoOp);
        else n_pass++;
        release_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        t_mr = 1; t_rd = 5'd5; t_rs2 = 5'd5; t_rs1 = 5'd1;
        @(negedge clk);
        n_checks++; if (ifa.Stall !== 1'b1 || ifa.NoOp !== 1'b1)
            $display("FAIL load_use_on got %b/%b want 1/1", ifa.Stall, ifa.NoOp);
        else n_pass++;
        advance();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (ifa.Stall !== 1'b0 || ifa.NoOp !== 1'b0)
            $display("FAIL load_use_off got %b/%b want 0/0", ifa.Stall, ifa.NoOp);
        else n_pass++;
        n_checks++; if (ifa.stall_cnt_o !== 16'd1)
            $display("FAIL load_use_cnt got %0d want 1", ifa.stall_cnt_o);
        else n_pass++;
        advance();
    endtask

    task automatic test_x0_priority();
        do_reset();
        t_mr = 1; t_rd = 5'd0; t_rs1 = 5'd0; t_rs2 = 5'd9;
        @(negedge clk);
        n_checks++; if (ifa.Stall !== 1'b0)
            $display("FAIL x0_stall got %b want 0", ifa.Stall);
        else n_pass++;
        advance();
        t_rd = 5'd3; t_rs1 = 5'd3; t_br = 1;
        @(negedge clk);
        n_checks++; if (ifa.Stall !== 1'b1 || ifa.Flush !== 1'b0)
            $display("FAIL lu_over_flush got stall=%b flush=%b want 1/0", ifa.Stall, ifa.Flush);
        else n_pass++;
        advance();
        t_mr = 0;
        @(negedge clk);
        n_checks++; if (ifa.Flush !== 1'b1 || ifa.flush_cnt_o !== 16'd0)
            $display("FAIL branch_flush got flush=%b cnt=%0d want 1/0", ifa.Flush, ifa.flush_cnt_o);
        else n_pass++;
        advance();
    endtask

    task automatic test_miss();
        do_reset();
        t_req = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (ifa.cpu_stall_o !== 1'b1)
                $display("FAIL miss_stall_c%0d got %b want 1", i, ifa.cpu_stall_o);
            else n_pass++;
            advance();
        end
        t_ack = 1;
        @(negedge clk);
        n_checks++; if (ifa.cpu_stall_o !== 1'b0)
            $display("FAIL miss_ack_release got %b want 0", ifa.cpu_stall_o);
        else n_pass++;
        advance();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (ifa.cpu_stall_o !== 1'b0 || ifa.mem_stall_cnt_o !== 16'd4)
            $display("FAIL miss_done got cpu=%b cnt=%0d want 0/4", ifa.cpu_stall_o, ifa.mem_stall_cnt_o);
        else n_pass++;
        advance();
        t_req = 1; t_ack = 1;
        @(negedge clk);
        n_checks++; if (ifa.cpu_stall_o !== 1'b0)
            $display("FAIL hit_no_stall got %b want 0", ifa.cpu_stall_o);
        else n_pass++;
        advance();
    endtask

    task automatic test_timeout();
        do_reset();
        t_req = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_checks++; if (ifb.err_o !== 1'b0 || ifb.cpu_stall_o !== 1'b1)
                $display("FAIL timeout_wait_c%0d got err=%b cpu=%b want 0/1", i, ifb.err_o, ifb.cpu_stall_o);
            else n_pass++;
            advance();
        end
        @(negedge clk);
        n_checks++; if (ifb.err_o !== 1'b1 || ifb.cpu_stall_o !== 1'b1)
            $display("FAIL timeout_err got err=%b cpu=%b want 1/1", ifb.err_o, ifb.cpu_stall_o);
        else n_pass++;
        advance();
        t_ack = 1;
        advance();
        @(negedge clk);
        n_checks++; if (ifb.err_o !== 1'b1 || ifb.cpu_stall_o !== 1'b1 || ifb.Flush !== 1'b0)
            $display("FAIL err_sticky got err=%b cpu=%b want 1/1", ifb.err_o, ifb.cpu_stall_o);
        else n_pass++;
        n_checks++; if (ifa.err_o !== 1'b0 || ifa.cpu_stall_o !== 1'b0)
            $display("FAIL long_timeout_ack got err=%b cpu=%b want 0/0", ifa.err_o, ifa.cpu_stall_o);
        else n_pass++;
        rst_n = 1'b0; t_req = 0; #1;
        n_checks++; if (ifb.err_o !== 1'b0 || ifb.cpu_stall_o !== 1'b0 || ifb.mem_stall_cnt_o !== 4'd0)
            $display("FAIL err_reset got err=%b cpu=%b cnt=%0d want 0/0/0", ifb.err_o, ifb.cpu_stall_o, ifb.mem_stall_cnt_o);
        else n_pass++;
        release_reset();
    endtask

    task automatic test_saturation();
        do_reset();
        t_br = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++; if (ifb.Flush !== 1'b1)
                $display("FAIL sat_flush_c%0d got %b want 1", i, ifb.Flush);
            else n_pass++;
            advance();
        end
        idle_inputs();
        @(negedge clk);
        n_checks++; if (ifb.flush_cnt_o !== 4'd15 || ifa.flush_cnt_o !== 16'd20)
            $display("FAIL sat_flush_cnt got %0d/%0d want 15/20", ifb.flush_cnt_o, ifa.flush_cnt_o);
        else n_pass++;
        advance();
    endtask

    task automatic test_reset_mid_miss();
        do_reset();
        t_req = 1;
        advance();
        advance();
        t_req = 0; #2;
        rst_n = 1'b0; #1;
        n_checks++; if (ifa.mem_stall_cnt_o !== 16'd0 || ifa.cpu_stall_o !== 1'b0 || ifa.err_o !== 1'b0)
            $display("FAIL mid_miss_reset got cnt=%0d cpu=%b want 0/0", ifa.mem_stall_cnt_o, ifa.cpu_stall_o);
        else n_pass++;
        t_req = 1; #1;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        advance();
        t_req = 0;
        @(negedge clk);
        n_checks++; if (ifa.cpu_stall_o !== 1'b1 || ifa.mem_stall_cnt_o !== 16'd1)
            $display("FAIL reenter_wait got cpu=%b cnt=%0d want 1/1", ifa.cpu_stall_o, ifa.mem_stall_cnt_o);
        else n_pass++;
        t_ack = 1;
        advance();
    endtask

    task automatic test_combined();
        do_reset();
        t_mr = 1; t_rd = 5'd3; t_rs1 = 5'd3; t_br = 1; t_req = 1; t_ack = 0;
        @(negedge clk);
        n_checks++; if ({ifa.Stall, ifa.NoOp, ifa.Flush, ifa.cpu_stall_o} !== 4'b0001)
            $display("FAIL all_at_once got %b%b%b%b want 0001", ifa.Stall, ifa.NoOp, ifa.Flush, ifa.cpu_stall_o);
        else n_pass++;
        advance();
        t_br = 0; t_ack = 1;
        @(negedge clk);
        n_checks++; if ({ifa.Stall, ifa.NoOp, ifa.cpu_stall_o} !== 3'b110)
            $display("FAIL ack_with_lu got %b%b%b want 110", ifa.Stall, ifa.NoOp, ifa.cpu_stall_o);
        else n_pass++;
        advance();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (ifa.stall_cnt_o !== 16'd1 || ifa.mem_stall_cnt_o !== 16'd1 || ifa.flush_cnt_o !== 16'd0)
            $display("FAIL combined_cnt got %0d/%0d/%0d want 1/1/0", ifa.stall_cnt_o, ifa.mem_stall_cnt_o, ifa.flush_cnt_o);
        else n_pass++;
        advance();
    endtask

    task automatic test_random();
        logic [4:0] obs, exp;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 149) do_reset();
            t_rs1 = 5'($urandom_range(0, 3));
            t_rs2 = 5'($urandom_range(0, 3));
            t_rd  = 5'($urandom_range(0, 3));
            t_mr  = ($urandom_range(0, 1) == 1);
            t_br  = ($urandom_range(0, 2) == 0);
            t_req = ($urandom_range(0, 1) == 1);
            t_ack = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            obs = {ifa.Stall, ifa.NoOp, ifa.Flush, ifa.cpu_stall_o, ifa.err_o};
            exp = {e_stall(0), e_stall(0), e_flush(0), e_cpu(0), m_err[0]};
            n_checks++; if (obs !== exp)
                $display("FAIL rand_flags_a c%0d got %b want %b", i, obs, exp);
            else n_pass++;
            obs = {ifb.Stall, ifb.NoOp, ifb.Flush, ifb.cpu_stall_o, ifb.err_o};
            exp = {e_stall(1), e_stall(1), e_flush(1), e_cpu(1), m_err[1]};
            n_checks++; if (obs !== exp)
                $display("FAIL rand_flags_b c%0d got %b want %b", i, obs, exp);
            else n_pass++;
            n_checks++; if (ifa.stall_cnt_o !== 16'(m_sc[0]) || ifa.mem_stall_cnt_o !== 16'(m_msc[0]) || ifa.flush_cnt_o !== 16'(m_fc[0]))
                $display("FAIL rand_cnt_a c%0d got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         ifa.stall_cnt_o, ifa.mem_stall_cnt_o, ifa.flush_cnt_o, m_sc[0], m_msc[0], m_fc[0]);
            else n_pass++;
            n_checks++; if (ifb.stall_cnt_o !== 4'(m_sc[1]) || ifb.mem_stall_cnt_o !== 4'(m_msc[1]) || ifb.flush_cnt_o !== 4'(m_fc[1]))
                $display("FAIL rand_cnt_b c%0d got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         ifb.stall_cnt_o, ifb.mem_stall_cnt_o, ifb.flush_cnt_o, m_sc[1], m_msc[1], m_fc[1]);
            else n_pass++;
            advance();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired after 500000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_x0_priority();
        test_miss();
        test_timeout();
        test_saturation();
        test_reset_mid_miss();
        test_combined();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of MEM_WAIT cycles before a memory timeout error.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of each performance counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk_i and rst_i.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  asynchronous active-low reset.
REQ-006 ID_rs1  in  5  rs1 index of the instruction in ID.
REQ-007 ID_rs2  in  5  rs2 index of the instruction in ID.
REQ-008 EX_rd  in  5  destination register of the instruction in EX.
REQ-009 EX_MemRead  in  1  instruction in EX is a load.
REQ-010 branch_taken  in  1  branch resolved taken in ID.
REQ-011 mem_req  in  1  MEM stage requests the data memory.
REQ-012 mem_ack  in  1  data memory completes the request this cycle.
REQ-013 Stall  out  1  hold PC and IF/ID (load-use).
REQ-014 NoOp  out  1  insert a bubble into ID/EX.
REQ-015 Flush  out  1  clear IF/ID.
REQ-016 cpu_stall_o  out  1  freeze the whole pipeline.
REQ-017 err_o  out  1  sticky memory timeout error.
REQ-018 stall_cnt_o, mem_stall_cnt_o, flush_cnt_o  out  CNT_W each  performance counters.

Function
REQ-019 load_use SHALL be EX_MemRead & (EX_rd != 0) & (EX_rd == ID_rs1 | EX_rd == ID_rs2).
REQ-020 Stall and NoOp SHALL both equal load_use & ~cpu_stall_o, combinationally, in the same cycle.
REQ-021 Flush SHALL equal branch_taken & ~load_use & ~cpu_stall_o, combinationally; load-use takes priority over a flush (the branch re-resolves next cycle).
REQ-022 The FSM SHALL have three states: RUN, MEM_WAIT and ERR.
REQ-023 RUN transitions: mem_req & ~mem_ack -> MEM_WAIT; otherwise stay in RUN.
REQ-024 MEM_WAIT transitions, in priority order:
  - mem_ack -> RUN;
  - else wait counter == TIMEOUT-1 -> ERR;
  - else stay in MEM_WAIT.
REQ-025 cpu_stall_o SHALL be (RUN & mem_req & ~mem_ack) | (MEM_WAIT & ~mem_ack) | ERR, combinationally.
  - A single-cycle hit (mem_req & mem_ack in RUN) SHALL produce no stall.
REQ-026 Wait counter:
  - cleared on entry to MEM_WAIT;
  - increments by 1 on each MEM_WAIT cycle without mem_ack;
  - width is clog2(TIMEOUT+1).
REQ-027 ERR SHALL be terminal until reset; err_o=1 and cpu_stall_o=1 throughout ERR.
REQ-028 stall_cnt_o SHALL increment on each cycle with Stall=1.
REQ-029 mem_stall_cnt_o SHALL increment on each cycle with cpu_stall_o=1.
REQ-030 flush_cnt_o SHALL increment on each cycle with Flush=1.
REQ-031 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 Simultaneous load_use, branch_taken and a new memory miss: only cpu_stall_o=1; Stall, NoOp and Flush=0 that cycle.
REQ-033 A mem_ack arriving in the same cycle as load_use SHALL release cpu_stall_o, and Stall/NoOp SHALL assert in that cycle.

Reset
REQ-034 While rst_i=0, the design SHALL immediately (asynchronously) drive:
  - state = RUN, wait counter = 0;
  - all three performance counters = 0;
  - err_o = 0.
REQ-035 Combinational outputs SHALL follow REQ-020/021/025 with state=RUN during reset.
REQ-036 Reset asserted in MEM_WAIT or ERR SHALL return the FSM to RUN.
  - After rst_i rises, a still-asserted mem_req & ~mem_ack re-enters MEM_WAIT on the next edge.

Verification
REQ-037 Load-use: EX_MemRead=1, EX_rd=5, ID_rs2=5, for 1 cycle -> Stall=NoOp=1 for that cycle only; stall_cnt_o=1.
REQ-038 x0 and priority:
  - EX_rd=0, EX_MemRead=1, ID_rs1=0 -> Stall=0;
  - EX_rd=3=ID_rs1 with branch_taken=1 -> Stall=1, Flush=0.
REQ-039 Miss: mem_req=1, with mem_ack rising 4 cycles later ->
  - cpu_stall_o=1 for exactly 4 cycles, then 0;
  - mem_stall_cnt_o=4;
  - FSM back in RUN.
REQ-040 Timeout with TIMEOUT=8: mem_req=1, mem_ack=0 held ->
  - ERR entered after 8 MEM_WAIT cycles;
  - err_o=1 and stays 1 when mem_ack later asserts;
  - rst_i pulse low clears it.
REQ-041 Saturation with CNT_W=4: branch_taken=1 for 20 cycles -> flush_cnt_o stops at 15.
REQ-042 Reset mid-miss: rst_i low in cycle 2 of MEM_WAIT ->
  - counters=0 and state=RUN immediately;
  - cpu_stall_o=0 if mem_req has dropped.
